// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the bit-serial adder controller:
//   - SA_DEFAULT_WIDTH : default operand/result width in bits
//   - sa_state_e       : controller state encoding (IDLE/RUN/DONE);
//                        the spare code 2'd3 is never entered and is
//                        decoded as IDLE by the controller.
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/fullAdder_1b.sv
// ---------------------------------------------------------------------------
// fullAdder_1b
//
// Combinational 1-bit full-adder cell. This is the only arithmetic element
// of the bit-serial adder; it is time-multiplexed over all operand bits.
//
// Ports:
//   a, b  : input  1  addend bits
//   ci    : input  1  carry in
//   s     : output 1  sum bit      (a ^ b ^ ci)
//   co    : output 1  carry out    (majority of a, b, ci)
// ---------------------------------------------------------------------------
module fullAdder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ab_x;

    assign ab_x = a ^ b;
    assign s    = ab_x ^ ci;
    assign co   = (a & b) | (ab_x & ci);

endmodule : fullAdder_1b

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. Adds two WIDTH-bit operands plus a carry-in
// over WIDTH clock cycles, LSB first, using a single 1-bit full-adder cell
// and a running carry register. Provides a start/busy/done handshake and a
// registered result: {cout, sum} = a + b + cin (mod 2^(WIDTH+1)).
//
// Parameters:
//   WIDTH : operand/result width in bits (>= 2)
//
// Ports:
//   clk   : input  1      rising-edge clock
//   rst   : input  1      synchronous, active-high reset (wins over start)
//   start : input  1      request; only honoured in IDLE
//   a, b  : input  WIDTH  operands, latched on the accepting edge
//   cin   : input  1      carry-in, latched on the accepting edge
//   busy  : output 1      high while in RUN or DONE
//   done  : output 1      one-cycle pulse; sum/cout valid
//   sum   : output WIDTH  registered result, holds until the next DONE
//   cout  : output 1      registered carry-out, holds until the next DONE
//
// Timing: start sampled at E0, bits 0..WIDTH-1 processed at E1..E_WIDTH,
// done high after E_WIDTH, back in IDLE after E_WIDTH+1.
// ---------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    sa_state_e        state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] s_sh_q,   s_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    // Full-adder cell: always looks at the current LSBs and running carry.
    logic fa_s;
    logic fa_co;

    fullAdder_1b u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Partial sum after this cycle's bit enters at the MSB. After WIDTH
    // shifts, bit 0 has travelled all the way down to position 0.
    logic [WIDTH-1:0] s_sh_next;
    assign s_sh_next = {fa_s, s_sh_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        s_sh_d   = s_sh_q;
        carry_d  = carry_q;
        bitcnt_d = bitcnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    s_sh_d   = '0;
                    carry_d  = cin;
                    bitcnt_d = '0;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                s_sh_d   = s_sh_next;
                carry_d  = fa_co;
                bitcnt_d = bitcnt_q + CNT_ONE;
                if (bitcnt_q == LAST_BIT) begin
                    // Result registers are only touched here, so they hold
                    // the previous result for the whole of RUN.
                    sum_d    = s_sh_next;
                    cout_d   = fa_co;
                    // Explicit wrap keeps non-power-of-two widths in range.
                    bitcnt_d = '0;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            // Spare encoding 2'd3: recover to IDLE.
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments so every flop samples the values from
    // before this edge; blocking here would make the order of statements
    // change the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            s_sh_q   <= '0;
            carry_q  <= 1'b0;
            bitcnt_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            s_sh_q   <= s_sh_d;
            carry_q  <= carry_d;
            bitcnt_q <= bitcnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, so there is no path
    // from any input to any output. Code 2'd3 decodes as IDLE (not busy).
    // ------------------------------------------------------------------
    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Self-checking bench for serial_adder_ctrl (WIDTH = 8). Expected results
// come from plain integer addition of the operands; expected timing comes
// from the start/done handshake rules (done WIDTH edges after acceptance,
// WIDTH+2 cycle repeat with start held high).
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model state: the last result the DUT should be showing.
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete add. Checks latency, busy span, result hold during RUN,
    // final result, and that nothing is queued afterwards. With poke set,
    // start is pulsed mid-RUN with different operands, which must be ignored.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_cin, input bit poke, input string tag);
        logic [W:0] ref_v;
        int         lat;
        ref_v = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};
        @(negedge clk);
        a = op_a; b = op_b; cin = op_cin; start = 1'b1;
        @(negedge clk);
        // Operands may change freely once accepted.
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        for (lat = 0; lat <= 3 * W; lat++) begin
            if (done === 1'b1) break;
            vec_cnt++;
            if (busy !== 1'b1 || sum !== exp_sum || cout !== exp_cout) begin
                err_cnt++;
                $display("FAIL %s run[%0d]: busy=%b sum=%h cout=%b, need busy=1 sum=%h cout=%b",
                         tag, lat, busy, sum, cout, exp_sum, exp_cout);
            end
            if (poke && lat == 3) begin
                start = 1'b1; a = W'(8'hAA); b = W'(8'h55);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        vec_cnt++;
        if (lat > 3 * W) begin
            err_cnt++;
            $display("FAIL %s timeout: no done within %0d cycles", tag, 3 * W);
            return;
        end
        if (lat != W || busy !== 1'b1 || sum !== ref_v[W-1:0] || cout !== ref_v[W]) begin
            err_cnt++;
            $display("FAIL %s done: lat=%0d busy=%b sum=%h cout=%b, need lat=%0d busy=1 sum=%h cout=%b",
                     tag, lat, busy, sum, cout, W, ref_v[W-1:0], ref_v[W]);
        end
        exp_sum  = ref_v[W-1:0];
        exp_cout = ref_v[W];
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vec_cnt++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== exp_sum || cout !== exp_cout) begin
                err_cnt++;
                $display("FAIL %s after[%0d]: busy=%b done=%b sum=%h cout=%b, need 0 0 %h %b",
                         tag, k, busy, done, sum, cout, exp_sum, exp_cout);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, need all zero",
                     busy, done, sum, cout);
        end
    endtask

    task automatic test_basic();
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, "basic_5a_3c");
    endtask

    task automatic test_ripple();
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, "ripple_ff_01");
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, "ripple_ff_ff_1");
    endtask

    task automatic test_start_ignored();
        do_op(8'h10, 8'h20, 1'b0, 1'b1, "start_in_run");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);   // four bits processed, bitcnt == 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b, need all zero",
                     busy, done, sum, cout);
        end
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            vec_cnt++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0) begin
                err_cnt++;
                $display("FAIL abort_idle[%0d]: busy=%b done=%b sum=%h, need 0 0 00",
                         k, busy, done, sum);
            end
        end
        do_op(8'h01, 8'h01, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        int  n_done;
        logic exp_done;
        logic exp_busy;
        n_done = 0;
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b1; start = 1'b1;
        for (int k = 0; k <= 3 * (W + 2) + W; k++) begin
            @(negedge clk);
            exp_done = (k >= W) && (((k - W) % (W + 2)) == 0);
            exp_busy = ((k % (W + 2)) != (W + 1));
            vec_cnt++;
            if (done !== exp_done || busy !== exp_busy) begin
                err_cnt++;
                $display("FAIL b2b[%0d]: done=%b busy=%b, need done=%b busy=%b",
                         k, done, busy, exp_done, exp_busy);
            end
            if (done === 1'b1) begin
                n_done++;
                vec_cnt++;
                if (sum !== 8'h08 || cout !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL b2b_result[%0d]: sum=%h cout=%b, need 08 0", k, sum, cout);
                end
            end
        end
        start = 1'b0;
        exp_sum = 8'h08; exp_cout = 1'b0;
        vec_cnt++;
        if (n_done != 4) begin
            err_cnt++;
            $display("FAIL b2b_count: %0d done pulses, need 4", n_done);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rst_start();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vec_cnt++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
                err_cnt++;
                $display("FAIL rst_start[%0d]: busy=%b done=%b sum=%h cout=%b, need all zero",
                         k, busy, done, sum, cout);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_rst_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
